vc_out_arbiter: RTL and testbench

Downstream stage of the per-VC input buffers (vc_buffer) in a router port. Takes the head-of-queue flit from each of N_VC buffers, picks one with round-robin arbitration, and holds the grant on that VC from a multi-flit head until its tail so packets never interleave on the link. The winning flit goes into a one-entry output register that drives the link or the crossbar input, tagged with its VC id.

---
 rtl/vc_out_arbiter.sv | 137 +++++++++++++
 tb/tb_vc_out_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_out_arbiter.sv
// Output arbiter for a router port. Picks one of N_VC head-of-queue flits round-robin,
// holds the grant for a whole multi-flit packet, and registers the winner with its VC id.
module vc_out_arbiter #(
  parameter int N_VC   = 3,
  parameter int FLIT_W = 34,
  parameter int VC_W   = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_VC*FLIT_W-1:0]   fdata_i,
  input  logic [N_VC-1:0]          valid_i,
  output logic [N_VC-1:0]          ready_o,
  output logic [FLIT_W-1:0]        fdata_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [VC_W-1:0]          vc_id_o,
  output logic                     err_o
);

  localparam logic [1:0]      TYPE_HEAD = 2'b00;
  localparam logic [1:0]      TYPE_TAIL = 2'b11;
  localparam logic [VC_W-1:0] RR_INIT   = VC_W'(N_VC - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_next;
  logic [VC_W-1:0]   lock_vc, lock_vc_next;
  logic [VC_W-1:0]   rr_ptr, rr_ptr_next;
  logic [VC_W-1:0]   grant;
  logic [VC_W-1:0]   idx;
  logic              grant_valid;
  logic              load;
  logic              xfer;
  logic              err_next;
  logic [FLIT_W-1:0] flit;
  logic [1:0]        flit_type;
  logic              size_nonzero;

  assign load = !valid_o || ready_i;

  // Candidate selection: the locked VC only, otherwise the first valid VC after rr_ptr.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    grant       = rr_ptr;
    grant_valid = 1'b0;
    idx         = '0;
    if (state == LOCKED) begin
      grant       = lock_vc;
      grant_valid = valid_i[lock_vc];
    end else begin
      for (int i = 1; i <= N_VC; i++) begin
        idx = VC_W'((int'(rr_ptr) + i) % N_VC);
        if (!grant_valid && valid_i[idx]) begin
          grant       = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign xfer         = grant_valid && load && !arst;
  assign flit         = fdata_i[int'(grant)*FLIT_W +: FLIT_W];
  assign flit_type    = flit[FLIT_W-1 -: 2];
  assign size_nonzero = |flit[29:22];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (arst) begin
      state   <= IDLE;
      lock_vc <= '0;
      rr_ptr  <= RR_INIT;
      err_o   <= 1'b0;
    end else begin
      state   <= state_next;
      lock_vc <= lock_vc_next;
      rr_ptr  <= rr_ptr_next;
      err_o   <= err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state;
    lock_vc_next = lock_vc;
    rr_ptr_next  = rr_ptr;
    if (xfer) begin
      unique case (state)
        IDLE: begin
          rr_ptr_next = grant;
          if (flit_type == TYPE_HEAD && size_nonzero) begin
            state_next   = LOCKED;
            lock_vc_next = grant;
          end
        end
        LOCKED: begin
          // A stray head restarts the packet on the same VC.
          if (flit_type == TYPE_TAIL)
            state_next = IDLE;
          else if (flit_type == TYPE_HEAD)
            state_next = size_nonzero ? LOCKED : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic: pop strobe and protocol error detection.
  always_comb begin
    ready_o  = '0;
    err_next = 1'b0;
    if (xfer) begin
      ready_o[grant] = 1'b1;
      if (state == IDLE)
        err_next = (flit_type != TYPE_HEAD);
      else
        err_next = (flit_type == TYPE_HEAD);
    end
  end

  // One-entry output register.
  always_ff @(posedge clk) begin
    // NOTE: the payload register is reset only because the link must show an all-zero flit after reset.
    if (arst) begin
      valid_o <= 1'b0;
      fdata_o <= '0;
      vc_id_o <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      fdata_o <= flit;
      vc_id_o <= grant;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Self-checking bench for vc_out_arbiter: queue-modelled upstream buffers and a
// packet-level reference model of arbitration, locking and the output register.
module tb_vc_out_arbiter;

  localparam int N_VC   = 3;
  localparam int FLIT_W = 34;
  localparam int VC_W   = 2;

  logic                   clk = 1'b0;
  logic                   arst;
  logic [N_VC*FLIT_W-1:0] fdata_i;
  logic [N_VC-1:0]        valid_i;
  logic [N_VC-1:0]        ready_o;
  logic [FLIT_W-1:0]      fdata_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [VC_W-1:0]        vc_id_o;
  logic                   err_o;

  vc_out_arbiter #(.N_VC(N_VC), .FLIT_W(FLIT_W), .VC_W(VC_W)) dut (
    .clk     (clk),
    .arst    (arst),
    .fdata_i (fdata_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .fdata_o (fdata_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .vc_id_o (vc_id_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Upstream per-VC buffers.
  logic [FLIT_W-1:0] q [N_VC][$];

  // Reference model state.
  bit                m_valid   = 1'b0;
  bit                m_err     = 1'b0;
  bit                m_locked  = 1'b0;
  logic [FLIT_W-1:0] m_data    = '0;
  int                m_vc      = 0;
  int                m_lock_vc = 0;
  int                m_rr      = N_VC - 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] typ, input int size);
    logic [21:0] pay;
    pay = 22'($urandom);
    return {typ, 2'b00, 8'(size), pay};
  endfunction

  // Head with size 0 is one flit; size s > 0 is head, s-1 bodies, tail.
  task automatic push_pkt(input int v, input int size, output int nflits);
    q[v].push_back(mk(2'b00, size));
    nflits = 1;
    if (size != 0) begin
      for (int b = 1; b < size; b++) begin
        q[v].push_back(mk($urandom_range(0, 1) ? 2'b01 : 2'b10, $urandom_range(0, 255)));
        nflits++;
      end
      q[v].push_back(mk(2'b11, $urandom_range(0, 255)));
      nflits++;
    end
  endtask

  function automatic bit all_empty();
    for (int v = 0; v < N_VC; v++)
      if (q[v].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive, check pop strobes, clock, update model, check outputs.
  task automatic step(input bit rdy, input bit rst);
    int                pop_vc;
    bit                load;
    logic [N_VC-1:0]   exp_ready;
    logic [N_VC-1:0]   hs;
    logic [FLIT_W-1:0] f;
    ready_i = rdy;
    arst    = rst;
    for (int v = 0; v < N_VC; v++) begin
      valid_i[v] = (q[v].size() != 0);
      fdata_i[v*FLIT_W +: FLIT_W] = valid_i[v] ? q[v][0] : '0;
    end
    #1;
    pop_vc = -1;
    load   = !m_valid || rdy;
    if (!rst && load) begin
      if (m_locked) begin
        if (q[m_lock_vc].size() != 0) pop_vc = m_lock_vc;
      end else begin
        for (int i = 1; i <= N_VC; i++) begin
          int v;
          v = (m_rr + i) % N_VC;
          if (pop_vc < 0 && q[v].size() != 0) pop_vc = v;
        end
      end
    end
    exp_ready = '0;
    if (pop_vc >= 0) exp_ready[pop_vc] = 1'b1;
    check("ready_o", 64'(ready_o), 64'(exp_ready));
    hs = valid_i & ready_o;
    f  = (pop_vc >= 0) ? q[pop_vc][0] : '0;

    @(posedge clk);
    for (int v = 0; v < N_VC; v++) begin
      if (rst) q[v].delete();
      else if (hs[v]) void'(q[v].pop_front());
    end

    if (rst) begin
      m_valid = 0; m_data = '0; m_vc = 0; m_err = 0;
      m_locked = 0; m_lock_vc = 0; m_rr = N_VC - 1;
    end else begin
      m_err = 0;
      if (pop_vc >= 0) begin
        m_data  = f;
        m_vc    = pop_vc;
        m_valid = 1;
        if (!m_locked) begin
          m_rr = pop_vc;
          if (f[33:32] != 2'b00) m_err = 1;
          else if (f[29:22] != 0) begin
            m_locked  = 1;
            m_lock_vc = pop_vc;
          end
        end else if (f[33:32] == 2'b11) begin
          m_locked = 0;
        end else if (f[33:32] == 2'b00) begin
          m_err    = 1;
          m_locked = (f[29:22] != 0);
        end
      end else if (rdy) begin
        m_valid = 0;
      end
    end

    #1;
    check("valid_o", 64'(valid_o), 64'(m_valid));
    check("fdata_o", 64'(fdata_o), 64'(m_data));
    check("vc_id_o", 64'(vc_id_o), 64'(m_vc));
    check("err_o",   64'(err_o),   64'(m_err));
  endtask

  task automatic drain(input int limit, input bit rand_rdy);
    int n = 0;
    while (!all_empty() && n < limit) begin
      step(rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
      n++;
    end
    check("drain_empty", 64'(all_empty()), 64'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  initial begin
    int nf, total, util;
    arst = 1'b1; ready_i = 1'b1; valid_i = '0; fdata_i = '0;

    // Reset with a flit pending upstream: no pops, outputs cleared.
    push_pkt(0, 0, nf);
    step(1'b1, 1'b1);
    push_pkt(1, 0, nf);
    step(1'b1, 1'b1);

    // Round-robin over single-flit packets: VC order 0,1,2,0,1,2.
    for (int k = 0; k < 2; k++)
      for (int v = 0; v < N_VC; v++) push_pkt(v, 0, nf);
    drain(20, 1'b0);

    // Packet lock on VC1 while VC0 and VC2 wait; then VC2, VC0.
    push_pkt(1, 3, nf);
    step(1'b1, 1'b0);
    push_pkt(0, 0, nf);
    push_pkt(2, 0, nf);
    drain(20, 1'b0);

    // Backpressure for five cycles with a flit held on the output.
    for (int v = 0; v < N_VC; v++) begin
      push_pkt(v, 0, nf);
      push_pkt(v, 2, nf);
    end
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    drain(40, 1'b0);

    // Protocol errors: stray body in IDLE, second head on a locked VC.
    q[2].push_back(mk(2'b01, 0));
    step(1'b1, 1'b0);
    q[0].push_back(mk(2'b00, 2));
    q[0].push_back(mk(2'b00, 1));
    q[0].push_back(mk(2'b11, 0));
    push_pkt(1, 0, nf);
    drain(20, 1'b0);

    // Reset in the middle of a 4-flit packet on VC0, then VC1 wins at once.
    push_pkt(0, 3, nf);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    push_pkt(1, 0, nf);
    step(1'b1, 1'b0);
    drain(20, 1'b0);

    // Single-VC streaming: full link utilisation.
    total = 0;
    for (int p = 0; p < 100; p++) begin
      push_pkt(0, $urandom_range(0, 4), nf);
      total += nf;
    end
    util = 0;
    repeat (total + 1) begin
      step(1'b1, 1'b0);
      if (valid_o === 1'b1) util++;
    end
    check("utilisation", 64'(util), 64'(total));
    check("stream_empty", 64'(all_empty()), 64'd1);

    // Random mixed traffic with random backpressure and occasional stray bodies.
    for (int v = 0; v < N_VC; v++)
      for (int p = 0; p < 12; p++) begin
        if ($urandom_range(0, 9) == 0) q[v].push_back(mk(2'b10, 0));
        push_pkt(v, $urandom_range(0, 4), nf);
      end
    drain(3000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
